// File: rtl/posit_encode_n32_es6_pipe3_pkg.sv
// Shared constants for the N=32, es=6 posit packing datapath.
package posit_pkg;

  localparam int N       = 32;
  localparam int ES      = 6;
  localparam int BS      = 5;
  localparam int SCALE_W = ES + BS + 1;
  localparam int K_W     = SCALE_W - ES;

  localparam logic [N-1:0] NAR    = 32'h8000_0000;
  localparam logic [N-1:0] MAXPOS = 32'h7FFF_FFFF;
  localparam logic [N-1:0] MINPOS = 32'h0000_0001;

  // Largest scale that still fits a regime; anything at or beyond saturates.
  localparam int SAT_SCALE = (N - 2) << ES;
  localparam int SAT_K     = N - 2;

endpackage

// File: rtl/posit_encode_n32_es6_pipe3_if.sv
// Operation bus of the posit encoder: unpacked operand in, packed posit out.
interface posit_encode_n32_es6_pipe3_if;
  import posit_pkg::*;

  logic               start;
  logic               sgn;
  logic               inf_in;
  logic               zero_in;
  logic [SCALE_W-1:0] scale;
  logic [N-1:0]       frac;
  logic               sticky;
  logic [N-1:0]       out;
  logic               done;
  logic               inf;
  logic               zero;

  modport master (
    output start, sgn, inf_in, zero_in, scale, frac, sticky,
    input  out, done, inf, zero
  );

  modport slave (
    input  start, sgn, inf_in, zero_in, scale, frac, sticky,
    output out, done, inf, zero
  );

endinterface

// File: rtl/posit_encode_n32_es6_pipe3_regime_pack.sv
// Combinational regime insertion: builds the unrounded posit magnitude and
// the guard/round/sticky bits that the rounding stage needs.
module posit_regime_pack
  import posit_pkg::*;
(
  input  logic [K_W-1:0] k,
  input  logic [ES-1:0]  e,
  input  logic [N-2:0]   frac,
  input  logic           sticky,
  output logic [N-2:0]   m,
  output logic           l,
  output logic           g,
  output logic           r,
  output logic           st,
  output logic           sat_hi,
  output logic           sat_lo
);

  localparam int FW = 2 * N;
  localparam int LW = $clog2(FW) + 1;

  localparam logic signed [K_W-1:0] K_SAT_HI = K_W'(SAT_K);
  localparam logic signed [K_W-1:0] K_SAT_LO = K_W'(-SAT_K);

  logic signed [K_W-1:0] ks;
  logic [LW-1:0]         r_len;
  logic [FW-1:0]         body;
  logic [FW-1:0]         regime;
  logic [FW-1:0]         field;

  assign ks = signed'(k);

  // Shift {e, frac} down by the regime length and lay the regime run above it.
  always_comb begin
    r_len  = '0;
    regime = '0;
    body   = {e, frac, {(FW-ES-N+1){1'b0}}};
    if (!ks[K_W-1]) begin
      r_len  = LW'(ks) + LW'(2);
      regime = ~({FW{1'b1}} >> (r_len - LW'(1)));
    end else begin
      r_len  = LW'(1) - LW'(ks);
      regime = {{(FW-1){1'b0}}, 1'b1} << (LW'(FW) - r_len);
    end
    field = regime | (body >> r_len);
  end

  assign m  = field[FW-1 -: N-1];
  assign l  = field[FW-N+1];
  assign g  = field[FW-N];
  assign r  = field[FW-N-1];
  assign st = (|field[FW-N-2:0]) | sticky;

  // Scale magnitudes of (N-2)*2^es or more cannot be represented.
  assign sat_hi = (ks >= K_SAT_HI);
  assign sat_lo = (ks < K_SAT_LO) || ((ks == K_SAT_LO) && (e == '0));

endmodule

// File: rtl/posit_encode_n32_es6_pipe3.sv
// Three-stage posit packer: input capture, regime packing, RNE rounding,
// then sign application and special-value override on the output register.
module posit_encode_n32_es6_pipe3
  import posit_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  posit_encode_n32_es6_pipe3_if.slave bus
);

  logic               v0, v1, v2;
  logic               s0_sgn, s0_inf, s0_zero, s0_sticky;
  logic [SCALE_W-1:0] s0_scale;
  logic [N-1:0]       s0_frac;

  logic               s1_sgn, s1_inf, s1_zero;
  logic [N-2:0]       s1_m;
  logic               s1_l, s1_g, s1_r, s1_st, s1_sat_hi, s1_sat_lo;

  logic               s2_sgn, s2_inf, s2_zero;
  logic [N-1:0]       s2_mag;

  logic [N-2:0]       pk_m;
  logic               pk_l, pk_g, pk_r, pk_st, pk_sat_hi, pk_sat_lo;
  logic               ulp;
  logic [N-1:0]       rnd_sum, rnd_mag;

  posit_regime_pack u_pack (
    .k      (s0_scale[SCALE_W-1:ES]),
    .e      (s0_scale[ES-1:0]),
    .frac   (s0_frac[N-2:0]),
    .sticky (s0_sticky),
    .m      (pk_m),
    .l      (pk_l),
    .g      (pk_g),
    .r      (pk_r),
    .st     (pk_st),
    .sat_hi (pk_sat_hi),
    .sat_lo (pk_sat_lo)
  );

  // Stage 0: capture the operand; the valid bit follows start.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= 1'b0;
      s0_sgn    <= 1'b0;
      s0_inf    <= 1'b0;
      s0_zero   <= 1'b0;
      s0_sticky <= 1'b0;
      s0_scale  <= '0;
      s0_frac   <= '0;
    end else begin
      v0        <= bus.start;
      s0_sgn    <= bus.sgn;
      s0_inf    <= bus.inf_in;
      s0_zero   <= bus.zero_in;
      s0_sticky <= bus.sticky;
      s0_scale  <= bus.scale;
      s0_frac   <= bus.frac;
    end
  end

  // Stage 1: register the packed magnitude; an unnormalized significand is flushed to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      s1_sgn    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_m      <= '0;
      s1_l      <= 1'b0;
      s1_g      <= 1'b0;
      s1_r      <= 1'b0;
      s1_st     <= 1'b0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
    end else begin
      v1        <= v0;
      s1_sgn    <= s0_sgn;
      s1_inf    <= s0_inf;
      s1_zero   <= s0_zero | ~s0_frac[N-1];
      s1_m      <= pk_m;
      s1_l      <= pk_l;
      s1_g      <= pk_g;
      s1_r      <= pk_r;
      s1_st     <= pk_st;
      s1_sat_hi <= pk_sat_hi;
      s1_sat_lo <= pk_sat_lo;
    end
  end

  // Round to nearest even, then clamp so the result never becomes zero or NaR.
  always_comb begin
    ulp     = s1_g & (s1_l | s1_r | s1_st);
    rnd_sum = {1'b0, s1_m} + {{(N-1){1'b0}}, ulp};
    rnd_mag = rnd_sum;
    if (s1_sat_hi)          rnd_mag = MAXPOS;
    else if (s1_sat_lo)     rnd_mag = MINPOS;
    else if (rnd_sum[N-1])  rnd_mag = MAXPOS;
    else if (rnd_sum == '0) rnd_mag = MINPOS;
  end

  // Stage 2: register the rounded, sign-free magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2      <= 1'b0;
      s2_sgn  <= 1'b0;
      s2_inf  <= 1'b0;
      s2_zero <= 1'b0;
      s2_mag  <= '0;
    end else begin
      v2      <= v1;
      s2_sgn  <= s1_sgn;
      s2_inf  <= s1_inf;
      s2_zero <= s1_zero;
      s2_mag  <= rnd_mag;
    end
  end

  // Stage 3: apply sign and specials; results only change on a valid operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out  <= '0;
      bus.done <= 1'b0;
      bus.inf  <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      bus.done <= v2;
      if (v2) begin
        bus.inf  <= s2_inf;
        bus.zero <= ~s2_inf & s2_zero;
        if (s2_inf)       bus.out <= NAR;
        else if (s2_zero) bus.out <= '0;
        else if (s2_sgn)  bus.out <= -s2_mag;
        else              bus.out <= s2_mag;
      end
    end
  end

endmodule

// File: tb/tb_posit_encode_n32_es6_pipe3.sv
// Self-checking bench for the pipelined N=32 es=6 posit encoder.
module tb_posit_encode_n32_es6_pipe3;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  posit_encode_n32_es6_pipe3_if bus ();

  posit_encode_n32_es6_pipe3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: build the posit bit string as a queue straight from the
  // encoding rules, then round and apply the sign arithmetically.
  function automatic logic [31:0] model(input logic s, input logic fi, input logic fz,
                                        input int sc, input logic [31:0] f, input logic stk);
    bit     q[$];
    int     k, e;
    longint m;
    bit     g, r, st;
    if (fi) return 32'h8000_0000;
    if (fz) return 32'h0000_0000;
    if (sc >= 1920)       m = 64'h7FFF_FFFF;
    else if (sc <= -1920) m = 1;
    else begin
      k = (sc >= 0) ? sc / 64 : -((-sc + 63) / 64);
      e = sc - k * 64;
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 5; i >= 0; i--) q.push_back(e[i]);
      for (int i = 30; i >= 0; i--) q.push_back(f[i]);
      while (q.size() < 34) q.push_back(1'b0);
      m = 0;
      for (int i = 0; i < 31; i++) m = m * 2 + longint'(q[i]);
      g  = q[31];
      r  = q[32];
      st = stk;
      for (int i = 33; i < q.size(); i++) st = st | q[i];
      if (g && (r || st || m[0])) m = m + 1;
      if (m >= 64'h8000_0000) m = 64'h7FFF_FFFF;
      if (m == 0) m = 1;
    end
    return s ? 32'(-m) : 32'(m);
  endfunction

  // Issue a single operation and wait (bounded) for its done pulse.
  task automatic do_op(input logic s, input logic fi, input logic fz, input int sc,
                       input logic [31:0] f, input logic stk,
                       output logic [31:0] o, output logic oi, output logic oz, output int lat);
    bus.sgn     = s;
    bus.inf_in  = fi;
    bus.zero_in = fz;
    bus.scale   = 12'(sc);
    bus.frac    = f;
    bus.sticky  = stk;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    o  = bus.out;
    oi = bus.inf;
    oz = bus.zero;
  endtask

  // Outputs while reset is held.
  task automatic test_reset;
    total++;
    if (bus.out !== 32'h0) begin bad++; $display("[TB] FAIL reset_out got=%h exp=00000000", bus.out); end
    total++;
    if ({bus.done, bus.inf, bus.zero} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=000", {bus.done, bus.inf, bus.zero});
    end
  endtask

  // Basic packing at a few scales and both signs, plus latency and pulse width.
  task automatic test_basic;
    int          sc_t[4]  = '{0, 64, -1, 0};
    logic        s_t[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_t[4] = '{32'h4000_0000, 32'h6000_0000, 32'h3F80_0000, 32'hC000_0000};
    logic [31:0] o;
    logic        oi, oz;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      do_op(s_t[i], 1'b0, 1'b0, sc_t[i], 32'h8000_0000, 1'b0, o, oi, oz, lat);
      total++;
      if (o !== exp_t[i]) begin bad++; $display("[TB] FAIL basic_out[%0d] got=%h exp=%h", i, o, exp_t[i]); end
      total++;
      if (lat !== 3) begin bad++; $display("[TB] FAIL basic_latency[%0d] got=%0d exp=3", i, lat); end
      total++;
      if ({oi, oz} !== 2'b00) begin bad++; $display("[TB] FAIL basic_flags[%0d] got=%b exp=00", i, {oi, oz}); end
      @(posedge clk); #1;
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse[%0d] got=%b exp=0", i, bus.done); end
      total++;
      if (bus.out !== exp_t[i]) begin bad++; $display("[TB] FAIL basic_hold[%0d] got=%h exp=%h", i, bus.out, exp_t[i]); end
    end
  endtask

  // Round-to-nearest-even tie and sticky cases.
  task automatic test_rne;
    logic [31:0] f_t[3]   = '{32'h8000_0080, 32'h8000_0180, 32'h8000_0080};
    logic        st_t[3]  = '{1'b0, 1'b0, 1'b1};
    logic [31:0] exp_t[3] = '{32'h4000_0000, 32'h4000_0002, 32'h4000_0001};
    logic [31:0] o;
    logic        oi, oz;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 1'b0, 1'b0, 0, f_t[i], st_t[i], o, oi, oz, lat);
      total++;
      if (o !== exp_t[i]) begin bad++; $display("[TB] FAIL rne[%0d] got=%h exp=%h", i, o, exp_t[i]); end
    end
  endtask

  // Saturation at and around the scale limits.
  task automatic test_saturation;
    int          sc_t[7] = '{2000, -2000, 2000, 1920, -1920, 1919, -1919};
    logic        s_t[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_t;
    logic [31:0] o;
    logic        oi, oz;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      do_op(s_t[i], 1'b0, 1'b0, sc_t[i], 32'hC000_0001, 1'b0, o, oi, oz, lat);
      if (i == 0)      exp_t = 32'h7FFF_FFFF;
      else if (i == 1) exp_t = 32'h0000_0001;
      else if (i == 2) exp_t = 32'h8000_0001;
      else             exp_t = model(s_t[i], 1'b0, 1'b0, sc_t[i], 32'hC000_0001, 1'b0);
      total++;
      if (o !== exp_t) begin bad++; $display("[TB] FAIL sat[%0d] scale=%0d got=%h exp=%h", i, sc_t[i], o, exp_t); end
    end
  endtask

  // NaR and zero overrides, including their priority.
  task automatic test_specials;
    logic [31:0] o;
    logic        oi, oz;
    int          lat;
    do_op(1'b1, 1'b1, 1'b1, 100, 32'h9234_5678, 1'b1, o, oi, oz, lat);
    total++;
    if ({o, oi, oz} !== {32'h8000_0000, 2'b10}) begin
      bad++; $display("[TB] FAIL nar got=%h/%b%b exp=80000000/10", o, oi, oz);
    end
    do_op(1'b1, 1'b0, 1'b1, -300, 32'hA234_5678, 1'b1, o, oi, oz, lat);
    total++;
    if ({o, oi, oz} !== {32'h0000_0000, 2'b01}) begin
      bad++; $display("[TB] FAIL zero got=%h/%b%b exp=00000000/01", o, oi, oz);
    end
  endtask

  // Random single operations over the full scale range.
  task automatic test_random;
    logic [31:0] o, f, exp_v;
    logic        oi, oz, s, stk;
    int          lat, sc;
    for (int i = 0; i < 60; i++) begin
      sc  = int'($urandom_range(0, 4095)) - 2048;
      f   = {1'b1, 31'($urandom)};
      s   = 1'($urandom);
      stk = 1'($urandom);
      exp_v = model(s, 1'b0, 1'b0, sc, f, stk);
      do_op(s, 1'b0, 1'b0, sc, f, stk, o, oi, oz, lat);
      total++;
      if ({o, oi, oz} !== {exp_v, 2'b00}) begin
        bad++; $display("[TB] FAIL random[%0d] scale=%0d frac=%h got=%h exp=%h", i, sc, f, o, exp_v);
      end
    end
  endtask

  // Eight consecutive starts must come out as eight consecutive, ordered results.
  task automatic test_back_to_back;
    logic [31:0] expq[$];
    logic [31:0] exp_v, f;
    logic        s, stk;
    int          sc, cnt, prev, first;
    cnt = 0; prev = -1; first = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        sc  = -1850 + c * 460 + int'($urandom_range(0, 63));
        f   = {1'b1, 31'($urandom)};
        s   = 1'($urandom);
        stk = 1'($urandom);
        bus.sgn = s; bus.inf_in = 1'b0; bus.zero_in = 1'b0;
        bus.scale = 12'(sc); bus.frac = f; bus.sticky = stk; bus.start = 1'b1;
        expq.push_back(model(s, 1'b0, 1'b0, sc, f, stk));
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("[TB] FAIL b2b_extra cycle=%0d got=%h exp=none", c, bus.out);
        end else begin
          exp_v = expq.pop_front();
          if (bus.out !== exp_v) begin bad++; $display("[TB] FAIL b2b_out[%0d] got=%h exp=%h", cnt, bus.out, exp_v); end
        end
        if (prev >= 0) begin
          total++;
          if (c != prev + 1) begin bad++; $display("[TB] FAIL b2b_gap got=%0d exp=%0d", c, prev + 1); end
        end else begin
          first = c;
        end
        prev = c;
        cnt++;
      end
    end
    bus.start = 1'b0;
    total++;
    if (cnt != 8) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=8", cnt); end
    total++;
    if (first != 3) begin bad++; $display("[TB] FAIL b2b_first got=%0d exp=3", first); end
  endtask

  // Reset in flight discards everything; a fresh start then completes normally.
  task automatic test_reset_mid;
    logic [31:0] o, f, exp_v;
    logic        oi, oz;
    int          lat, seen, sc;
    for (int i = 0; i < 3; i++) begin
      bus.sgn = 1'b0; bus.inf_in = 1'b0; bus.zero_in = 1'b0;
      bus.scale = 12'(100 * i + 7); bus.frac = {1'b1, 31'($urandom)}; bus.sticky = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bus.out, bus.done, bus.inf, bus.zero} !== 35'h0) begin
      bad++; $display("[TB] FAIL midreset_outputs got=%h/%b%b%b exp=0", bus.out, bus.done, bus.inf, bus.zero);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("[TB] FAIL midreset_done got=%0d exp=0", seen); end

    // A start sampled together with reset is dropped as well.
    bus.scale = 12'(5); bus.frac = 32'h8000_0000; bus.start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("[TB] FAIL rst_start_done got=%0d exp=0", seen); end

    sc    = -777;
    f     = {1'b1, 31'($urandom)};
    exp_v = model(1'b1, 1'b0, 1'b0, sc, f, 1'b1);
    do_op(1'b1, 1'b0, 1'b0, sc, f, 1'b1, o, oi, oz, lat);
    total++;
    if (lat != 3) begin bad++; $display("[TB] FAIL postreset_latency got=%0d exp=3", lat); end
    total++;
    if (o !== exp_v) begin bad++; $display("[TB] FAIL postreset_out got=%h exp=%h", o, exp_v); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.sgn = 1'b0; bus.inf_in = 1'b0; bus.zero_in = 1'b0;
    bus.scale = '0; bus.frac = '0; bus.sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic;
    test_rne;
    test_saturation;
    test_specials;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_encode_n32_es6_pipe3.md
# posit_encode_n32_es6_pipe3

Pipelined posit encoder for N=32, es=6. It takes an unpacked sign, a signed combined scale, a normalized fraction and a sticky bit, and packs them into a 32-bit posit. Packing includes regime generation, saturation, round-to-nearest-even and two's-complement sign application. It is the packing end of the posit datapath and the counterpart of the posit field extractor, for use as the shared back end of adder, multiplier and converter pipelines. It accepts one operation per clock and uses the same start/done valid-pipe convention as the posit arithmetic units.

## Interface
- N, 32, posit width
- es, 6, exponent field width
- Bs, 5, log2(N); regime-count width
- clk  in  1  clock; all flops on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  input operation valid
- sgn  in  1  result sign (1 = negative)
- inf_in  in  1  force NaR result
- zero_in  in  1  force zero result
- scale  in  es+Bs+1 (12)  signed two's-complement scale, value = k·2^es + e
- frac  in  N  normalized significand; frac[N-1] is the hidden 1; frac[N-2:0] are fraction bits
- sticky  in  1  OR of all significand bits below frac[0]
- out  out  N  packed posit
- done  out  1  out valid, one-cycle pulse per accepted start
- inf  out  1  out is NaR
- zero  out  1  out is zero

## Operation
- **Stage 0 (register inputs).** Capture all inputs. A valid bit follows start.
- **Stage 1 (regime and field split).**
  - k = scale >>> es (arithmetic shift); e = scale[es-1:0].
  - For k ≥ 0 the regime is k+1 ones followed by a 0. For k < 0 it is −k zeros followed by a 1. Regime length is r_len = k+2 or −k+1.
- **Saturation.**
  - scale ≥ (N−2)·2^es = 1920 gives 0x7FFFFFFF (maxpos).
  - scale ≤ −1920 gives 0x00000001 (minpos).
  - The rounding step is skipped for both.
- **Packing.**
  - Form a 2N-bit field {regime pattern, e, frac[N-2:0], zero pad} left-aligned below the sign position.
  - The regime is inserted by a right shift of {e, frac} by r_len.
  - The top N−1 bits form the magnitude M.
  - L is the LSB of M. G is the next bit below it, R the bit below G. St is the OR of all lower field bits and the sticky input.
- **Rounding (stage 2, RNE).**
  - ulp = G·(R|St) | L·G·~(R|St). M = M + ulp.
  - Never rounds to 0: a result of 0 becomes minpos.
  - Never rounds into the sign bit: a carry into bit N−1 clamps to maxpos.
- **Sign (stage 3).** out = sgn ? −{0,M} : {0,M}.
- **Specials (override the computed value).**
  - inf_in=1 gives out=0x80000000, inf=1, zero=0. inf_in has priority over zero_in.
  - Otherwise zero_in=1 gives out=0, zero=1.
  - In both cases frac, scale and sgn are ignored.
- frac[N-1]=0 with neither inf_in nor zero_in set is illegal input. The output is then unspecified but done still pulses.

## Timing
- Latency: start sampled at rising edge t, so out/inf/zero/done are valid after edge t+3. done stays high for exactly one cycle.
- Fully pipelined, no backpressure. Back-to-back starts give back-to-back done pulses in the same order.
- out/inf/zero hold their last value while done=0.
- Reset values: out=0, done=0, inf=0, zero=0, and all stage valid bits are 0.
- Reset mid-operation: rst high at an edge discards every in-flight operation, and no done is produced for them. start sampled in the same cycle as rst is also discarded. The first done after rst deasserts comes no earlier than 3 edges after the first start sampled with rst=0.

## Structure
- **Package `posit_pkg`** holds:
  - N, ES, BS
  - SCALE_W = ES+BS+1
  - NAR = 32'h8000_0000, MAXPOS = 32'h7FFF_FFFF, MINPOS = 32'h0000_0001
  - SAT_SCALE = (N−2)<<ES
- **Sub-module `posit_regime_pack`** is combinational. It maps (k, e, frac, sticky) to (M, L, G, R, St, sat_hi, sat_lo). It is reused by the encoders of other N/es configurations.
- All pipeline registers live in the top module.

## Test plan
- **Basic packing:** start with sgn=0, scale=0, frac=0x80000000, sticky=0 → out=0x40000000 after 3 edges; done pulse; inf=zero=0. Then scale=64 → 0x60000000; scale=−1 → 0x3F800000; sgn=1, scale=0 → 0xC0000000.
- **RNE:** at scale=0 the kept fraction is frac[30:8].
  - frac=0x80000080, sticky=0 (tie, L=0) → 0x40000000.
  - frac=0x80000180 (tie, L=1) → 0x40000002.
  - frac=0x80000080, sticky=1 → 0x40000001.
- **Saturation:** scale=2000 → 0x7FFFFFFF; scale=−2000 → 0x00000001; sgn=1, scale=2000 → 0x80000001.
- **Specials:** inf_in=1 together with zero_in=1 → 0x80000000, inf=1. zero_in=1 → 0x00000000, zero=1.
- **Throughput:** 8 consecutive starts with distinct scales → 8 consecutive done pulses, results in input order, matching a reference model.
- **Reset:** issue 3 starts, then assert rst for 1 cycle one edge after the last start → no done, all outputs 0. A subsequent start completes normally 3 edges later.
